// File: rtl/ghash_pkg.sv
// Shared constants and state encoding for the bit-serial GHASH accumulator.
package ghash_pkg;

    localparam int BLK_W = 128;
    localparam int ITER  = 128;

    // Reduction constant of the GCM field in reflected bit order (bit 127 = x^0).
    localparam logic [BLK_W-1:0] GF_R = {8'hE1, 120'h0};

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/ghash_accum_if.sv
// Block stream handshake between the AEAD datapath (master) and the accumulator (slave).
interface ghash_accum_if;
    import ghash_pkg::*;

    logic             valid;
    logic             ready;
    logic [BLK_W-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/gf128_mul_step.sv
// One shift-and-add iteration of the serial GF(2^128) multiply.
module gf128_mul_step
    import ghash_pkg::*;
(
    input  logic [BLK_W-1:0] z,
    input  logic [BLK_W-1:0] v,
    input  logic             h_bit,
    output logic [BLK_W-1:0] z_next,
    output logic [BLK_W-1:0] v_next
);

    // Accumulate V when the key bit is set; multiply V by x with reduction.
    always_comb begin
        // NOTE: outputs get an unconditional value on every path, so no latch is inferred.
        z_next = h_bit ? (z ^ v) : z;
        v_next = (v >> 1) ^ (v[0] ? GF_R : '0);
    end

endmodule

// File: rtl/ghash_accum.sv
// Bit-serial GHASH accumulator: folds each block as Y = (Y ^ X) * H, one key bit per cycle.
module ghash_accum
    import ghash_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BLK_W-1:0] H,
    input  logic             init,
    ghash_accum_if.slave     blk,
    output logic             busy,
    output logic [BLK_W-1:0] y_out,
    output logic             tag_valid
);

    state_t           state;
    logic [6:0]       cnt;
    logic [BLK_W-1:0] y;
    logic [BLK_W-1:0] z;
    logic [BLK_W-1:0] v;
    logic             last;
    logic [BLK_W-1:0] z_next;
    logic [BLK_W-1:0] v_next;
    logic             h_bit;

    // Iteration i consumes key bit H[127-i]; ~cnt is 127-cnt for a 7-bit counter.
    assign h_bit = H[~cnt];

    gf128_mul_step u_step (
        .z      (z),
        .v      (v),
        .h_bit  (h_bit),
        .z_next (z_next),
        .v_next (v_next)
    );

    // Ready depends only on the FSM state and init, never on blk.valid.
    assign blk.ready = (state == IDLE) && !init;
    assign busy      = (state == MUL);
    assign y_out     = y;

    // FSM, iteration counter and Y/Z/V registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            y         <= '0;
            z         <= '0;
            v         <= '0;
            last      <= 1'b0;
            tag_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (init) begin
                        y         <= '0;
                        tag_valid <= 1'b0;
                    end else if (blk.valid) begin
                        v         <= y ^ blk.data;
                        z         <= '0;
                        cnt       <= '0;
                        last      <= blk.last;
                        tag_valid <= 1'b0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    z   <= z_next;
                    v   <= v_next;
                    cnt <= cnt + 7'd1;
                    // Counter wraps to 0 on the same edge the FSM leaves MUL.
                    if (cnt == 7'(ITER - 1)) begin
                        y     <= z_next;
                        state <= IDLE;
                        if (last) tag_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
